// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encoding and
// the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, right-shifting register; SerIn enters at the MSB and the
// LSB is presented on SerOut.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load,
    input  logic             Shift,
    input  logic             SerIn,
    input  logic [WIDTH-1:0] ParIn,
    output logic [WIDTH-1:0] ParOut,
    output logic             SerOut
);

    logic [WIDTH-1:0] data_q;

    // Load takes priority over Shift so a new operand always lands intact.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            data_q <= '0;
        end else if (Load) begin
            data_q <= ParIn;
        end else if (Shift) begin
            data_q <= {SerIn, data_q[WIDTH-1:1]};
        end
    end

    assign ParOut = data_q;
    assign SerOut = data_q[0];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: feeds operands LSB-first into an external
// full-adder cell and gathers its sum bits into a registered result.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             CinInit,
    output logic             DataA,
    output logic             DataB,
    output logic             Cin,
    input  logic             Sum,
    input  logic             Cout,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CoutFinal
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state, state_next;
    logic load, shift, last_bit;
    logic [CNT_W-1:0] cnt;
    logic carry_q;
    logic [WIDTH-1:0] a_par, b_par, sum_par;
    logic a_ser, b_ser, sum_ser;
    logic unused_bits;

    assign last_bit = (cnt == LAST_CNT);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The last sum bit and final carry come straight from the cell on the
    // closing edge, so the result is assembled from the cell plus sum_sr.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            carry_q   <= 1'b0;
            cnt       <= '0;
            Result    <= '0;
            CoutFinal <= 1'b0;
        end else if (load) begin
            carry_q <= CinInit;
            cnt     <= '0;
        end else if (shift) begin
            carry_q <= Cout;
            if (last_bit) begin
                Result    <= {Sum, sum_par[WIDTH-1:1]};
                CoutFinal <= Cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
        .Clk(Clk), .Rst_n(Rst_n), .Load(load), .Shift(shift),
        .SerIn(1'b0), .ParIn(OpA), .ParOut(a_par), .SerOut(a_ser)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
        .Clk(Clk), .Rst_n(Rst_n), .Load(load), .Shift(shift),
        .SerIn(1'b0), .ParIn(OpB), .ParOut(b_par), .SerOut(b_ser)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_sum_sr (
        .Clk(Clk), .Rst_n(Rst_n), .Load(1'b0), .Shift(shift),
        .SerIn(Sum), .ParIn('0), .ParOut(sum_par), .SerOut(sum_ser)
    );

    assign unused_bits = ^{a_par, b_par, sum_par[0], sum_ser};

    assign DataA = a_ser;
    assign DataB = b_ser;
    assign Cin   = carry_q;
    assign Busy  = (state == SHIFT);
    assign Done  = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl with a behavioural
// full-adder cell closing the loop.
module tb_serial_adder_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Start;
    logic [7:0] OpA, OpB;
    logic       CinInit;
    logic       DataA, DataB, Cin;
    logic       Sum, Cout;
    logic       Busy, Done;
    logic [7:0] Result;
    logic       CoutFinal;

    int testCount = 0;
    int failCount = 0;

    always #5 Clk = ~Clk;

    assign Sum  = DataA ^ DataB ^ Cin;
    assign Cout = (DataA & DataB) | (Cin & (DataA ^ DataB));

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .OpA(OpA), .OpB(OpB), .CinInit(CinInit),
        .DataA(DataA), .DataB(DataB), .Cin(Cin),
        .Sum(Sum), .Cout(Cout),
        .Busy(Busy), .Done(Done),
        .Result(Result), .CoutFinal(CoutFinal)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where Done is seen
    // (or after the cycle budget runs out).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 output int edges, output int busyN,
                                 output logic [7:0] cinTr, output logic [7:0] aTr);
        OpA = a; OpB = b; CinInit = c; Start = 1'b1;
        edges = 0; busyN = 0; cinTr = '0; aTr = '0;
        @(posedge Clk); edges++;
        @(negedge Clk); Start = 1'b0;
        while (!Done && edges < 40) begin
            if (Busy && busyN < 8) begin
                cinTr[busyN[2:0]] = Cin;
                aTr[busyN[2:0]]   = DataA;
                busyN++;
            end else if (Busy) begin
                busyN++;
            end
            @(posedge Clk); edges++;
            @(negedge Clk);
        end
    endtask

    initial begin
        int edges, busyN, doneCount, d1, d2;
        logic [7:0] cinTr, aTr, r1, r2;
        logic c1, c2;

        Rst_n = 1'b0; Start = 1'b0; OpA = '0; OpB = '0; CinInit = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst busy", 32'(Busy), 32'd0);
        checkOutput("rst done", 32'(Done), 32'd0);
        checkOutput("rst result", 32'(Result), 32'h00);
        checkOutput("rst coutfinal", 32'(CoutFinal), 32'd0);
        checkOutput("rst dataa", 32'(DataA), 32'd0);
        checkOutput("rst datab", 32'(DataB), 32'd0);
        checkOutput("rst cin", 32'(Cin), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // 0x3C + 0x55 = 0x091
        applyStimulus(8'h3C, 8'h55, 1'b0, edges, busyN, cinTr, aTr);
        checkOutput("t1 edges", 32'(edges), 32'd9);
        checkOutput("t1 done", 32'(Done), 32'd1);
        checkOutput("t1 busy at done", 32'(Busy), 32'd0);
        checkOutput("t1 result", 32'(Result), 32'h91);
        checkOutput("t1 coutfinal", 32'(CoutFinal), 32'd0);
        checkOutput("t1 busy cycles", 32'(busyN), 32'd8);
        checkOutput("t1 cin trace", 32'(cinTr), 32'hF8);
        checkOutput("t1 dataa trace", 32'(aTr), 32'h3C);
        @(negedge Clk);
        checkOutput("t1 done pulse", 32'(Done), 32'd0);
        repeat (3) @(negedge Clk);
        checkOutput("t1 result held", 32'(Result), 32'h91);

        // 0xFF + 0x01 = 0x100
        applyStimulus(8'hFF, 8'h01, 1'b0, edges, busyN, cinTr, aTr);
        checkOutput("t2 done", 32'(Done), 32'd1);
        checkOutput("t2 result", 32'(Result), 32'h00);
        checkOutput("t2 coutfinal", 32'(CoutFinal), 32'd1);
        checkOutput("t2 busy cycles", 32'(busyN), 32'd8);
        checkOutput("t2 cin trace", 32'(cinTr), 32'hFE);
        @(negedge Clk);

        // 0xFF + 0xFF + 1 = 0x1FF
        applyStimulus(8'hFF, 8'hFF, 1'b1, edges, busyN, cinTr, aTr);
        checkOutput("t3 done", 32'(Done), 32'd1);
        checkOutput("t3 result", 32'(Result), 32'hFF);
        checkOutput("t3 coutfinal", 32'(CoutFinal), 32'd1);
        checkOutput("t3 cin trace", 32'(cinTr), 32'hFF);
        @(negedge Clk);

        // Start pulsed mid-SHIFT must be ignored: 0x12 + 0x34 = 0x046
        OpA = 8'h12; OpB = 8'h34; CinInit = 1'b0; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk); Start = 1'b0;
        doneCount = 0; d1 = 0; r1 = '0; c1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                Start = 1'b1; OpA = 8'hFF; OpB = 8'hFF; CinInit = 1'b1;
            end
            if (i == 4) Start = 1'b0;
            if (Done) begin
                doneCount++; d1 = i; r1 = Result; c1 = CoutFinal;
            end
            @(negedge Clk);
        end
        checkOutput("t4 done count", 32'(doneCount), 32'd1);
        checkOutput("t4 done cycle", 32'(d1), 32'd9);
        checkOutput("t4 result", 32'(r1), 32'h46);
        checkOutput("t4 coutfinal", 32'(c1), 32'd0);

        // Reset in SHIFT cycle 5 abandons the add
        OpA = 8'h0F; OpB = 8'h0F; CinInit = 1'b0; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk); Start = 1'b0;
        repeat (4) @(negedge Clk);
        checkOutput("t5 busy before rst", 32'(Busy), 32'd1);
        Rst_n = 1'b0;
        @(negedge Clk);
        checkOutput("t5 busy", 32'(Busy), 32'd0);
        checkOutput("t5 done", 32'(Done), 32'd0);
        checkOutput("t5 result", 32'(Result), 32'h00);
        checkOutput("t5 coutfinal", 32'(CoutFinal), 32'd0);
        checkOutput("t5 cin", 32'(Cin), 32'd0);
        checkOutput("t5 dataa", 32'(DataA), 32'd0);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        checkOutput("t5 idle busy", 32'(Busy), 32'd0);
        checkOutput("t5 idle done", 32'(Done), 32'd0);
        // 0xA7 + 0x5A + 1 = 0x102
        applyStimulus(8'hA7, 8'h5A, 1'b1, edges, busyN, cinTr, aTr);
        checkOutput("t5 fresh edges", 32'(edges), 32'd9);
        checkOutput("t5 fresh result", 32'(Result), 32'h02);
        checkOutput("t5 fresh coutfinal", 32'(CoutFinal), 32'd1);
        @(negedge Clk);

        // Start held high: back-to-back adds every WIDTH+2 cycles
        OpA = 8'h01; OpB = 8'h01; CinInit = 1'b0; Start = 1'b1;
        edges = 0; doneCount = 0; d1 = 0; d2 = 0;
        r1 = '0; r2 = '0; c1 = 1'b1; c2 = 1'b0;
        while (doneCount < 2 && edges < 40) begin
            @(posedge Clk); edges++;
            @(negedge Clk);
            if (edges == 1) begin
                OpA = 8'h80; OpB = 8'h80;
            end
            if (Done) begin
                if (doneCount == 0) begin
                    d1 = edges; r1 = Result; c1 = CoutFinal;
                end else begin
                    d2 = edges; r2 = Result; c2 = CoutFinal;
                end
                doneCount++;
            end
        end
        Start = 1'b0;
        checkOutput("t6 done count", 32'(doneCount), 32'd2);
        checkOutput("t6 first done", 32'(d1), 32'd9);
        checkOutput("t6 spacing", 32'(d2 - d1), 32'd10);
        checkOutput("t6 result1", 32'(r1), 32'h02);
        checkOutput("t6 cout1", 32'(c1), 32'd0);
        checkOutput("t6 result2", 32'(r2), 32'h00);
        checkOutput("t6 cout2", 32'(c2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
